// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and transmit sequencer feeding uarttop's dintx/newd handshake
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    dintx,
  output logic          newd,
  input  logic          donetx,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_e;

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;
  logic [7:0]      dintx_q, dintx_d;
  logic            wr_accept;
  logic            pop;
  logic            done_rise;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign dintx    = dintx_q;
  assign newd     = (state_q == S_SEND);
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    wr_accept  = wr_en && !full;
    pop        = (state_q == S_LOAD);
    done_rise  = donetx && !done_q;
    done_d     = donetx;
    overflow_d = wr_en && full;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    dintx_d    = dintx_q;
    state_d    = state_q;

    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({wr_accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: if (!empty) state_d = S_LOAD;
      S_LOAD: begin
        dintx_d = mem_q[rd_ptr_q];
        state_d = S_SEND;
      end
      S_SEND: if (done_rise) state_d = S_GAP;
      // Wait for donetx to drop so uarttop never sees a stale done with a new request.
      S_GAP:  if (!donetx) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b1;
      dintx_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      dintx_q    <= dintx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a behavioural donetx responder
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] dintx;
  logic       newd;
  logic       donetx;
  logic       busy;

  int checks;
  int errors;
  logic [7:0] sb [$];

  uart_tx_fifo #(.DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .dintx    (dintx),
    .newd     (newd),
    .donetx   (donetx),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic write_byte(input logic [7:0] b, input bit stored);
    wr_en   = 1'b1;
    wr_data = b;
    if (stored) sb.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  task automatic serve_frame(input int hold);
    int t;
    logic [7:0] exp;
    t = 0;
    while (newd !== 1'b1 && t < 300) begin
      step();
      t++;
    end
    checks++;
    if (newd !== 1'b1) begin
      errors++;
      $display("FAIL frame_timeout: newd=%b required 1", newd);
      return;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_frame: dintx=%02h with nothing outstanding", dintx);
    end else begin
      exp = sb.pop_front();
      if (dintx !== exp) begin
        errors++;
        $display("FAIL frame_data: dintx=%02h required %02h", dintx, exp);
      end
    end
    step();
    donetx = 1'b1;
    step();
    checks++;
    if (newd !== 1'b0) begin
      errors++;
      $display("FAIL newd_fall: newd=%b required 0 one clk after donetx rise", newd);
    end
    for (int i = 0; i < hold; i++) begin
      step();
      checks++;
      if (newd !== 1'b0) begin
        errors++;
        $display("FAIL repeat_while_done: newd=%b required 0 at hold cycle %0d", newd, i);
      end
    end
    donetx = 1'b0;
  endtask

  task automatic check_idle_empty(input string tag);
    repeat (3) step();
    checks++;
    if (empty !== 1'b1 || busy !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL %s_end: empty=%b busy=%b count=%0d required 1 0 0", tag, empty, busy, count);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (full !== 1'b0 || empty !== 1'b1 || count !== 5'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_fifo: full=%b empty=%b count=%0d overflow=%b required 0 1 0 0",
               full, empty, count, overflow);
    end
    checks++;
    if (dintx !== 8'h00 || newd !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_tx: dintx=%02h newd=%b busy=%b required 00 0 0", dintx, newd, busy);
    end
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_single_byte();
    do_reset();
    write_byte(8'hA5, 1'b1);
    checks++;
    if (empty !== 1'b0 || count !== 5'd1) begin
      errors++;
      $display("FAIL single_write: empty=%b count=%0d required 0 1", empty, count);
    end
    step();
    checks++;
    if (busy !== 1'b1 || newd !== 1'b0) begin
      errors++;
      $display("FAIL single_load: busy=%b newd=%b required 1 0", busy, newd);
    end
    step();
    checks++;
    if (newd !== 1'b1 || dintx !== 8'hA5) begin
      errors++;
      $display("FAIL single_send: newd=%b dintx=%02h required 1 a5", newd, dintx);
    end
    serve_frame(3);
    check_idle_empty("single");
  endtask

  task automatic test_burst_order();
    int maxc;
    do_reset();
    maxc = 0;
    for (int i = 1; i <= 5; i++) begin
      write_byte(8'(i), 1'b1);
      if (int'(count) > maxc) maxc = int'(count);
    end
    checks++;
    if (maxc != 4) begin
      errors++;
      $display("FAIL burst_count: max count=%0d required 4", maxc);
    end
    for (int i = 0; i < 5; i++) serve_frame(100);
    check_idle_empty("burst");
  endtask

  task automatic test_full_overflow();
    do_reset();
    for (int k = 1; k <= 18; k++) begin
      write_byte(8'(8'h10 + k), k <= 17);
      if (k == 16) begin
        checks++;
        if (count !== 5'd15 || full !== 1'b0) begin
          errors++;
          $display("FAIL full_16th: count=%0d full=%b required 15 0", count, full);
        end
      end
      if (k == 17) begin
        checks++;
        if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL full_17th: count=%0d full=%b overflow=%b required 16 1 0", count, full, overflow);
        end
      end
      if (k == 18) begin
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
          errors++;
          $display("FAIL overflow_pulse: overflow=%b count=%0d required 1 16", overflow, count);
        end
      end
    end
    step();
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: overflow=%b required 0", overflow);
    end
    for (int i = 0; i < 17; i++) serve_frame(1);
    check_idle_empty("full");
  endtask

  task automatic test_push_pop();
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) write_byte(8'(8'h61 + i), 1'b1);
    exp = sb.pop_front();
    checks++;
    if (newd !== 1'b1 || dintx !== exp || count !== 5'd3) begin
      errors++;
      $display("FAIL pp_setup: newd=%b dintx=%02h count=%0d required 1 %02h 3", newd, dintx, count, exp);
    end
    donetx = 1'b1;
    step();
    donetx = 1'b0;
    step();
    step();
    checks++;
    if (busy !== 1'b1 || newd !== 1'b0 || count !== 5'd3) begin
      errors++;
      $display("FAIL pp_load: busy=%b newd=%b count=%0d required 1 0 3", busy, newd, count);
    end
    write_byte(8'h65, 1'b1);
    checks++;
    if (count !== 5'd3) begin
      errors++;
      $display("FAIL pp_count: count=%0d required 3", count);
    end
    for (int i = 0; i < 4; i++) serve_frame(2);
    check_idle_empty("pp");
  endtask

  task automatic test_wrap();
    int peak;
    do_reset();
    peak = 0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 10; i++) begin
        write_byte(8'((c * 10 + i) * 7), 1'b1);
        if (int'(count) > peak) peak = int'(count);
      end
      for (int i = 0; i < 10; i++) serve_frame(1);
    end
    checks++;
    if (peak > 16) begin
      errors++;
      $display("FAIL wrap_peak: peak count=%0d required <= 16", peak);
    end
    check_idle_empty("wrap");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 5; i++) write_byte(8'(8'h30 + i), 1'b1);
    exp = sb.pop_front();
    checks++;
    if (newd !== 1'b1 || dintx !== exp) begin
      errors++;
      $display("FAIL mid_setup: newd=%b dintx=%02h required 1 %02h", newd, dintx, exp);
    end
    donetx = 1'b1;
    rst    = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    checks++;
    if (newd !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: newd=%b count=%0d empty=%b busy=%b required 0 0 1 0",
               newd, count, empty, busy);
    end
    repeat (5) step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_idle_hold: busy=%b required 0", busy);
    end
    write_byte(8'h55, 1'b1);
    repeat (6) step();
    checks++;
    if (newd !== 1'b1 || dintx !== 8'h55) begin
      errors++;
      $display("FAIL mid_no_edge: newd=%b dintx=%02h required 1 55", newd, dintx);
    end
    donetx = 1'b0;
    step();
    serve_frame(2);
    check_idle_empty("mid");
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    donetx  = 1'b0;
    repeat (2) step();
    test_reset();
    test_single_byte();
    test_burst_order();
    test_full_overflow();
    test_push_pop();
    test_wrap();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
